// File: rtl/cpu8_pkg.sv
// rtl/cpu8_pkg.sv - opcodes, state encoding and instruction field slices for the 8-bit CPU
package cpu8_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_INC  = 4'h7;
  localparam logic [3:0] OP_DEC  = 4'h8;
  localparam logic [3:0] OP_LDI  = 4'h9;
  localparam logic [3:0] OP_SHL  = 4'hA;
  localparam logic [3:0] OP_SHR  = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IMM,
    S_WB,
    S_HALT
  } state_t;

  // Reserved opcodes C..E behave exactly like NOP.
  function automatic logic is_nop(input logic [3:0] op);
    return (op == OP_NOP) || (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/control_sequencer_alu.sv
// rtl/control_sequencer_alu.sv - combinational 8-bit ALU with carry/borrow/shift-out flag
module alu8
  import cpu8_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       c
);

  always_comb begin
    y = 8'h00;
    c = 1'b0;
    case (op)
      OP_MOV: y = b;
      OP_ADD: {c, y} = {1'b0, a} + {1'b0, b};
      // Bit 8 of a 9-bit difference is the borrow.
      OP_SUB: {c, y} = {1'b0, a} - {1'b0, b};
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_INC: {c, y} = {1'b0, a} + 9'd1;
      OP_DEC: {c, y} = {1'b0, a} - 9'd1;
      OP_SHL: {c, y} = {a, 1'b0};
      OP_SHR: begin
        y = {1'b0, a[7:1]};
        c = a[0];
      end
      default: begin
        y = 8'h00;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute/writeback controller feeding the register file
module control_sequencer
  import cpu8_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] imem_addr,
  output logic       imem_req,
  input  logic [7:0] imem_data,
  input  logic       imem_valid,
  output logic [1:0] ReadRegA,
  output logic [1:0] ReadRegB,
  input  logic [7:0] ReadDataA,
  input  logic [7:0] ReadDataB,
  output logic       WriteEnable,
  output logic [1:0] WriteReg,
  output logic [7:0] WriteData,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic       halted
);

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] res;
  logic       carry_l;
  logic       zf;
  logic       cf;
  logic [7:0] alu_y;
  logic       alu_c;
  logic [3:0] opcode;

  assign opcode = ir[OPC_MSB:OPC_LSB];

  alu8 u_alu (
    .op(opcode),
    .a (ReadDataA),
    .b (ReadDataB),
    .y (alu_y),
    .c (alu_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 8'h00;
      res     <= 8'h00;
      carry_l <= 1'b0;
      zf      <= 1'b0;
      cf      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_valid) begin
            ir    <= imem_data;
            pc    <= pc + 8'd1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_nop(opcode))        state <= S_FETCH;
          else if (opcode == OP_HALT) state <= S_HALT;
          else if (opcode == OP_LDI)  state <= S_IMM;
          else                        state <= S_EXEC;
        end
        S_EXEC: begin
          res     <= alu_y;
          carry_l <= alu_c;
          state   <= S_WB;
        end
        S_IMM: begin
          if (imem_valid) begin
            res     <= imem_data;
            carry_l <= 1'b0;
            pc      <= pc + 8'd1;
            state   <= S_WB;
          end
        end
        S_WB: begin
          zf    <= (res == 8'h00);
          cf    <= carry_l;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Reset gates the handshake and the write strobe so a write in flight is dropped.
  assign imem_req    = !reset && ((state == S_FETCH) || (state == S_IMM));
  assign WriteEnable = !reset && (state == S_WB);
  assign imem_addr   = pc;
  assign ReadRegA    = ir[RD_MSB:RD_LSB];
  assign ReadRegB    = ir[RS_MSB:RS_LSB];
  assign WriteReg    = ir[RD_MSB:RD_LSB];
  assign WriteData   = res;
  assign zero_flag   = zf;
  assign carry_flag  = cf;
  assign halted      = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed vector bench for control_sequencer
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_en = 1'b1;
  logic [7:0] prog [256];
  logic [7:0] rf [4];

  logic [7:0] imem_addr, imem_data, ReadDataA, ReadDataB, WriteData;
  logic       imem_req, imem_valid, WriteEnable, zero_flag, carry_flag, halted;
  logic [1:0] ReadRegA, ReadRegB, WriteReg;

  logic       reset2 = 1'b1;
  logic [7:0] prog2 [256];
  logic [7:0] addr2, data2, wdata2;
  logic       req2, we2, z2, c2, halted2;
  logic [1:0] ra2, rb2, wr2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign imem_data  = prog[imem_addr];
  assign imem_valid = valid_en;
  assign ReadDataA  = rf[ReadRegA];
  assign ReadDataB  = rf[ReadRegB];
  assign data2      = prog2[addr2];

  control_sequencer #(.RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .imem_valid(imem_valid), .ReadRegA(ReadRegA),
    .ReadRegB(ReadRegB), .ReadDataA(ReadDataA), .ReadDataB(ReadDataB),
    .WriteEnable(WriteEnable), .WriteReg(WriteReg), .WriteData(WriteData),
    .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted)
  );

  control_sequencer #(.RESET_PC(8'hFF)) dut_ff (
    .clk(clk), .reset(reset2), .imem_addr(addr2), .imem_req(req2),
    .imem_data(data2), .imem_valid(1'b1), .ReadRegA(ra2),
    .ReadRegB(rb2), .ReadDataA(8'h00), .ReadDataB(8'h00),
    .WriteEnable(we2), .WriteReg(wr2), .WriteData(wdata2),
    .zero_flag(z2), .carry_flag(c2), .halted(halted2)
  );

  typedef struct {
    logic [7:0]  instr;
    logic [31:0] rfv;   // {r3, r2, r1, r0}
    logic [7:0]  exp_data;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Register-file model commits whatever write strobe is visible just before the edge.
  task automatic step();
    logic       we;
    logic [1:0] wr;
    logic [7:0] wd;
    @(negedge clk);
    we = WriteEnable;
    wr = WriteReg;
    wd = WriteData;
    @(posedge clk);
    if (we) rf[wr] = wd;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic load(input logic [31:0] rfv);
    for (int k = 0; k < 4; k++) rf[k] = rfv[8*k +: 8];
    for (int k = 0; k < 256; k++) prog[k] = 8'h00;
  endtask

  task automatic wait_we(input int budget, output int n);
    n = 0;
    while (!WriteEnable && n < budget) begin
      step();
      n++;
    end
    if (!WriteEnable) chk("we_timeout", 16'd0, 16'd1);
  endtask

  initial begin
    int n;
    int errs;
    logic [7:0] a0;
    logic [1:0] rd;

    vecs[0]  = '{8'h26, 32'h04030200, 8'h05, 1'b0, 1'b0};
    vecs[1]  = '{8'h26, 32'h0020F000, 8'h10, 1'b1, 1'b0};
    vecs[2]  = '{8'h26, 32'h00808000, 8'h00, 1'b1, 1'b1};
    vecs[3]  = '{8'h36, 32'h00050500, 8'h00, 1'b0, 1'b1};
    vecs[4]  = '{8'h31, 32'h00000200, 8'hFE, 1'b1, 1'b0};
    vecs[5]  = '{8'h16, 32'h00AA0700, 8'hAA, 1'b0, 1'b0};
    vecs[6]  = '{8'h46, 32'h000FF000, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{8'h56, 32'h000FF000, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{8'h66, 32'h000FFF00, 8'hF0, 1'b0, 1'b0};
    vecs[9]  = '{8'h76, 32'h00007F00, 8'h80, 1'b0, 1'b0};
    vecs[10] = '{8'h86, 32'h00000000, 8'hFF, 1'b1, 1'b0};
    vecs[11] = '{8'hA6, 32'h00008100, 8'h02, 1'b1, 1'b0};
    vecs[12] = '{8'hB6, 32'h00000100, 8'h00, 1'b1, 1'b1};
    for (int k = 0; k < 256; k++) prog2[k] = 8'h00;
    prog2[8'h00] = 8'hF0;

    // Single ALU instruction per vector from a fresh reset.
    for (int i = 0; i < 13; i++) begin
      load(vecs[i].rfv);
      prog[0] = vecs[i].instr;
      do_reset();
      chk($sformatf("v%0d_reset_req", i), 16'(imem_req), 16'd1);
      chk($sformatf("v%0d_reset_flags", i), {14'd0, zero_flag, carry_flag}, 16'd0);
      wait_we(8, n);
      rd = vecs[i].instr[3:2];
      chk($sformatf("v%0d_latency", i), 16'(n), 16'd3);
      chk($sformatf("v%0d_wreg", i), 16'(WriteReg), 16'(rd));
      chk($sformatf("v%0d_wdata", i), 16'(WriteData), 16'(vecs[i].exp_data));
      step();
      chk($sformatf("v%0d_z", i), 16'(zero_flag), 16'(vecs[i].exp_z));
      chk($sformatf("v%0d_c", i), 16'(carry_flag), 16'(vecs[i].exp_c));
      chk($sformatf("v%0d_addr", i), 16'(imem_addr), 16'h01);
      chk($sformatf("v%0d_rf", i), 16'(rf[rd]), 16'(vecs[i].exp_data));
      chk($sformatf("v%0d_we_low", i), 16'(WriteEnable), 16'd0);
    end

    // LDI r3,FF then INC r3 wraps to 00 with carry.
    load(32'h0);
    prog[0] = 8'h9C; prog[1] = 8'hFF; prog[2] = 8'h7C;
    do_reset();
    wait_we(8, n);
    chk("ldi_latency", 16'(n), 16'd3);
    chk("ldi_wreg", 16'(WriteReg), 16'd3);
    chk("ldi_wdata", 16'(WriteData), 16'hFF);
    step();
    chk("ldi_flags", {14'd0, zero_flag, carry_flag}, 16'd0);
    wait_we(8, n);
    chk("inc_latency", 16'(n), 16'd3);
    chk("inc_wdata", 16'(WriteData), 16'h00);
    step();
    chk("inc_zc", {14'd0, zero_flag, carry_flag}, 16'b11);
    chk("inc_pc", 16'(imem_addr), 16'h03);
    chk("inc_rf3", 16'(rf[3]), 16'h00);

    // Fetch stalls for three cycles with valid low.
    load(32'h04030200);
    prog[0] = 8'h26;
    valid_en = 1'b0;
    do_reset();
    a0 = imem_addr;
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (imem_req !== 1'b1 || imem_addr !== a0 || WriteEnable !== 1'b0) errs++;
    end
    chk("stall_stable", 16'(errs), 16'd0);
    chk("stall_pc", 16'(imem_addr), 16'h00);
    valid_en = 1'b1;
    #1;
    wait_we(8, n);
    chk("stall_resume_latency", 16'(n), 16'd3);
    chk("stall_resume_wdata", 16'(WriteData), 16'h05);

    // Reset during WB drops the write and clears flags.
    load(32'h0020F000);
    prog[0] = 8'h80; prog[1] = 8'h26;
    do_reset();
    wait_we(8, n);
    chk("wb1_wdata", 16'(WriteData), 16'hFF);
    step();
    chk("wb1_c", 16'(carry_flag), 16'd1);
    wait_we(8, n);
    chk("wb2_wdata", 16'(WriteData), 16'h10);
    reset = 1'b1;
    #1;
    chk("rst_wb_we_gated", 16'(WriteEnable), 16'd0);
    step();
    chk("rst_wb_rf_kept", 16'(rf[1]), 16'hF0);
    chk("rst_wb_we", 16'(WriteEnable), 16'd0);
    chk("rst_wb_addr", 16'(imem_addr), 16'h00);
    chk("rst_wb_flags", {14'd0, zero_flag, carry_flag}, 16'd0);
    reset = 1'b0;
    #1;
    chk("rst_wb_fetch_req", 16'(imem_req), 16'd1);

    // RESET_PC=FF: NOP at FF, wrap to 00, HALT.
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    #1;
    chk("wrap_addr_ff", 16'(addr2), 16'hFF);
    chk("wrap_req", 16'(req2), 16'd1);
    step();
    step();
    chk("wrap_addr_00", 16'(addr2), 16'h00);
    step();
    step();
    chk("halt_state", {14'd0, halted2, req2}, 16'b10);
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (halted2 !== 1'b1 || req2 !== 1'b0 || we2 !== 1'b0) errs++;
    end
    chk("halt_hold", 16'(errs), 16'd0);
    reset2 = 1'b1;
    step();
    chk("halt_cleared", {14'd0, halted2, req2}, 16'b00);
    reset2 = 1'b0;
    #1;
    chk("halt_restart", {7'd0, req2, addr2}, {7'd0, 1'b1, 8'hFF});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
